mem_arbiter: RTL and testbench

- Sits between the two memory requesters (instruction fetch, load/store buffer) and the byte-serial memory controller.
- Grants the single memory port to one requester at a time with round-robin fairness, holds the grant until the controller's done pulse, and returns results.
- Handles pipeline flush (clr) without corrupting in-flight stores.
- Throttles stores to the UART/IO region using io_buffer_full plus a minimum inter-store gap.

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and the load/store buffer for a single
// byte-serial memory port, with flush handling and IO-store throttling.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IO_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              clr,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [2:0]        lsb_ls_type,
  input  logic [DATA_W-1:0] lsb_st_val,
  output logic              lsb_done,
  output logic [DATA_W-1:0] lsb_ld_val,
  output logic              mc_enable,
  output logic              mc_wr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [2:0]        mc_ls_type,
  output logic [DATA_W-1:0] mc_st_val,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_result
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, IO_WAIT} state_e;
  localparam int GW = $clog2(IO_GAP + 2);

  state_e            state_q, state_d;
  logic              last_lsb_q, last_lsb_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              io_st_q, io_st_d;
  logic              mc_enable_q, mc_enable_d, mc_wr_q, mc_wr_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic [2:0]        mc_ls_type_q, mc_ls_type_d;
  logic [DATA_W-1:0] mc_st_val_q, mc_st_val_d;
  logic              if_done_q, if_done_d, lsb_done_q, lsb_done_d;
  logic [DATA_W-1:0] if_data_q, if_data_d, lsb_ld_val_q, lsb_ld_val_d;

  logic any_req, pick_lsb, lsb_is_io, io_go, ls_abort;
  assign any_req   = if_req | lsb_req;
  assign pick_lsb  = lsb_req & (~if_req | ~last_lsb_q);
  assign lsb_is_io = lsb_wr & (lsb_addr[17:16] == 2'b11);
  assign io_go     = ~io_buffer_full & (gap_q == '0);
  // Stores are already committed once issued, so only loads can be flushed.
  assign ls_abort  = clr & ~mc_wr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_lsb_q <= 1'b1;
      gap_q      <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      last_lsb_q <= last_lsb_d;
      gap_q      <= gap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_lsb_d = last_lsb_q;
    gap_d      = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    case (state_q)
      IDLE:    if (any_req && !clr)
                 state_d = !pick_lsb ? BUSY_IF : (lsb_is_io ? IO_WAIT : BUSY_LS);
      BUSY_IF: if (clr) state_d = IDLE;
               else if (mc_done) begin state_d = IDLE; last_lsb_d = 1'b0; end
      BUSY_LS: if (ls_abort) state_d = IDLE;
               else if (mc_done) begin
                 state_d    = IDLE;
                 last_lsb_d = 1'b1;
                 if (io_st_q) gap_d = GW'(IO_GAP);
               end
      IO_WAIT: if (clr) state_d = IDLE;
               else if (io_go) state_d = BUSY_LS;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mc_enable_d  = mc_enable_q;
    mc_wr_d      = mc_wr_q;
    mc_addr_d    = mc_addr_q;
    mc_ls_type_d = mc_ls_type_q;
    mc_st_val_d  = mc_st_val_q;
    io_st_d      = io_st_q;
    if_done_d    = 1'b0;
    lsb_done_d   = 1'b0;
    if_data_d    = if_data_q;
    lsb_ld_val_d = lsb_ld_val_q;
    case (state_q)
      IDLE: if (any_req && !clr) begin
        if (pick_lsb) begin
          mc_wr_d      = lsb_wr;
          mc_addr_d    = lsb_addr;
          mc_ls_type_d = lsb_ls_type;
          mc_st_val_d  = lsb_st_val;
          io_st_d      = lsb_is_io;
          mc_enable_d  = ~lsb_is_io;
        end else begin
          mc_wr_d      = 1'b0;
          mc_addr_d    = if_addr;
          mc_ls_type_d = 3'b111;
          mc_st_val_d  = '0;
          io_st_d      = 1'b0;
          mc_enable_d  = 1'b1;
        end
      end
      BUSY_IF: if (clr) mc_enable_d = 1'b0;
               else if (mc_done) begin
                 mc_enable_d = 1'b0;
                 if_done_d   = 1'b1;
                 if_data_d   = mc_result;
               end
      BUSY_LS: if (ls_abort) mc_enable_d = 1'b0;
               else if (mc_done) begin
                 mc_enable_d  = 1'b0;
                 lsb_done_d   = 1'b1;
                 lsb_ld_val_d = mc_wr_q ? '0 : mc_result;
               end
      IO_WAIT: if (clr) mc_enable_d = 1'b0;
               else if (io_go) mc_enable_d = 1'b1;
      default: mc_enable_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mc_enable_q  <= 1'b0;
      mc_wr_q      <= 1'b0;
      mc_addr_q    <= '0;
      mc_ls_type_q <= '0;
      mc_st_val_q  <= '0;
      io_st_q      <= 1'b0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      if_data_q    <= '0;
      lsb_ld_val_q <= '0;
    end else if (rdy) begin
      mc_enable_q  <= mc_enable_d;
      mc_wr_q      <= mc_wr_d;
      mc_addr_q    <= mc_addr_d;
      mc_ls_type_q <= mc_ls_type_d;
      mc_st_val_q  <= mc_st_val_d;
      io_st_q      <= io_st_d;
      if_done_q    <= if_done_d;
      lsb_done_q   <= lsb_done_d;
      if_data_q    <= if_data_d;
      lsb_ld_val_q <= lsb_ld_val_d;
    end
  end

  assign mc_enable  = mc_enable_q;
  assign mc_wr      = mc_wr_q;
  assign mc_addr    = mc_addr_q;
  assign mc_ls_type = mc_ls_type_q;
  assign mc_st_val  = mc_st_val_q;
  assign if_done    = if_done_q;
  assign if_data    = if_data_q;
  assign lsb_done   = lsb_done_q;
  assign lsb_ld_val = lsb_ld_val_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: one vector per clock, outputs checked just after the edge.
module tb_mem_arbiter;
  logic        clk = 1'b0, rst_n, rdy, clr, io_full;
  logic        if_req, if_done, lsb_req, lsb_wr, lsb_done, mc_enable, mc_wr, mc_done;
  logic [31:0] if_addr, if_data, lsb_addr, lsb_st_val, lsb_ld_val, mc_addr, mc_st_val, mc_result;
  logic [2:0]  lsb_ls_type, mc_ls_type;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clr(clr), .io_buffer_full(io_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_ls_type(lsb_ls_type),
    .lsb_st_val(lsb_st_val), .lsb_done(lsb_done), .lsb_ld_val(lsb_ld_val),
    .mc_enable(mc_enable), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_ls_type(mc_ls_type),
    .mc_st_val(mc_st_val), .mc_done(mc_done), .mc_result(mc_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rs, rd, cl, fu, ir; logic [31:0] ia;
    logic lr, lw; logic [31:0] la; logic [2:0] lt; logic [31:0] lv;
    logic md; logic [31:0] mr;
    logic een, ewr; logic [31:0] ead; logic [2:0] ety; logic [31:0] esv;
    logic eid; logic [31:0] eidt; logic eld; logic [31:0] eldv;
  } vec_t;

  vec_t vt[$];
  int   applied = 0, miscompares = 0;

  function automatic vec_t V(
    input logic rs, rd, cl, fu, ir, input logic [31:0] ia,
    input logic lr, lw, input logic [31:0] la, input logic [2:0] lt, input logic [31:0] lv,
    input logic md, input logic [31:0] mr,
    input logic een, ewr, input logic [31:0] ead, input logic [2:0] ety, input logic [31:0] esv,
    input logic eid, input logic [31:0] eidt, input logic eld, input logic [31:0] eldv);
    vec_t v;
    v.rs = rs; v.rd = rd; v.cl = cl; v.fu = fu; v.ir = ir; v.ia = ia;
    v.lr = lr; v.lw = lw; v.la = la; v.lt = lt; v.lv = lv; v.md = md; v.mr = mr;
    v.een = een; v.ewr = ewr; v.ead = ead; v.ety = ety; v.esv = esv;
    v.eid = eid; v.eidt = eidt; v.eld = eld; v.eldv = eldv;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Fields only matter when the corresponding enable/pulse is expected high.
  function automatic logic [159:0] pack(input logic en, wr, input logic [31:0] ad, input logic [2:0] ty,
      input logic [31:0] sv, input logic id, input logic [31:0] idt, input logic ld,
      input logic [31:0] ldv, input logic men, mid, mld);
    return {25'd0, en, id, ld, men ? {wr, ad, ty, sv} : 68'd0, mid ? idt : 32'd0, mld ? ldv : 32'd0};
  endfunction

  initial begin
    rst_n = 0; rdy = 1; clr = 0; io_full = 0; if_req = 0; if_addr = 0; lsb_req = 0; lsb_wr = 0;
    lsb_addr = 0; lsb_ls_type = 0; lsb_st_val = 0; mc_done = 0; mc_result = 0;

    //            rs rd cl fu ir ia         lr lw la         lt lv            md mr            en wr ea         et esv           id idt           ld ldv
    vt.push_back(V(0,1,0,0, 0,0,          0,0,0,         0,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 1,'h100,      0,0,0,         0,0,           0,0,           1,0,'h100,     7,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 1,'h100,      0,0,0,         0,0,           0,0,           1,0,'h100,     7,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 1,'h100,      0,0,0,         0,0,           1,'hDEADBEEF,  0,0,0,         0,0,           1,'hDEADBEEF,  0,0));
    vt.push_back(V(1,1,0,0, 0,0,          0,0,0,         0,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    // both requesting, last grant IF -> LSB, then alternation
    for (int i = 0; i < 3; i++)
      vt.push_back(V(1,1,0,0, 1,'h104,    1,0,'h40,      2,0,           0,0,           1,0,'h40,      2,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 1,'h104,      1,0,'h40,      2,0,           1,'h11111111,  0,0,0,         0,0,           0,0,           1,'h11111111));
    vt.push_back(V(1,1,0,0, 1,'h104,      0,0,0,         0,0,           0,0,           1,0,'h104,     7,0,           0,0,           0,0));
    for (int i = 0; i < 2; i++)
      vt.push_back(V(1,1,0,0, 1,'h104,    1,0,'h40,      2,0,           0,0,           1,0,'h104,     7,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 1,'h104,      1,0,'h40,      2,0,           1,'h22222222,  0,0,0,         0,0,           1,'h22222222,  0,0));
    vt.push_back(V(1,1,0,0, 0,0,          1,0,'h40,      2,0,           0,0,           1,0,'h40,      2,0,           0,0,           0,0));
    for (int i = 0; i < 2; i++)
      vt.push_back(V(1,1,0,0, 1,'h108,    1,0,'h40,      2,0,           0,0,           1,0,'h40,      2,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 1,'h108,      1,0,'h40,      2,0,           1,'h33333333,  0,0,0,         0,0,           0,0,           1,'h33333333));
    vt.push_back(V(1,1,0,0, 1,'h108,      0,0,0,         0,0,           0,0,           1,0,'h108,     7,0,           0,0,           0,0));
    for (int i = 0; i < 2; i++)
      vt.push_back(V(1,1,0,0, 1,'h108,    0,0,0,         0,0,           0,0,           1,0,'h108,     7,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 1,'h108,      0,0,0,         0,0,           1,'h44444444,  0,0,0,         0,0,           1,'h44444444,  0,0));
    vt.push_back(V(1,1,0,0, 0,0,          0,0,0,         0,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    // IO store held off by io_buffer_full for 5 cycles
    for (int i = 0; i < 5; i++)
      vt.push_back(V(1,1,0,1, 0,0,        1,1,'h30000,   2,'hA5A5A5A5,  0,0,           0,0,0,         0,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 0,0,          1,1,'h30000,   2,'hA5A5A5A5,  0,0,           1,1,'h30000,   2,'hA5A5A5A5,  0,0,           0,0));
    vt.push_back(V(1,1,0,0, 0,0,          1,1,'h30000,   2,'hA5A5A5A5,  1,'hFFFFFFFF,  0,0,0,         0,0,           0,0,           1,0));
    vt.push_back(V(1,1,0,0, 0,0,          0,0,0,         0,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 0,0,          1,1,'h30004,   2,'h5A5A5A5A,  0,0,           0,0,0,         0,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 0,0,          1,1,'h30004,   2,'h5A5A5A5A,  0,0,           1,1,'h30004,   2,'h5A5A5A5A,  0,0,           0,0));
    vt.push_back(V(1,1,0,0, 0,0,          1,1,'h30004,   2,'h5A5A5A5A,  1,0,           0,0,0,         0,0,           0,0,           1,0));
    vt.push_back(V(1,1,0,0, 0,0,          0,0,0,         0,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    // clr aborts fetch; stray mc_done in IDLE ignored; clr blocks a new grant
    vt.push_back(V(1,1,0,0, 1,'h200,      0,0,0,         0,0,           0,0,           1,0,'h200,     7,0,           0,0,           0,0));
    vt.push_back(V(1,1,1,0, 1,'h200,      0,0,0,         0,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 0,0,          0,0,0,         0,0,           1,'hBAD,       0,0,0,         0,0,           0,0,           0,0));
    vt.push_back(V(1,1,1,0, 1,'h300,      0,0,0,         0,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 0,0,          0,0,0,         0,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    // clr during a store: store survives
    vt.push_back(V(1,1,0,0, 0,0,          1,1,'h1000,    2,'hCAFEF00D,  0,0,           1,1,'h1000,    2,'hCAFEF00D,  0,0,           0,0));
    vt.push_back(V(1,1,1,0, 0,0,          1,1,'h1000,    2,'hCAFEF00D,  0,0,           1,1,'h1000,    2,'hCAFEF00D,  0,0,           0,0));
    vt.push_back(V(1,1,0,0, 0,0,          1,1,'h1000,    2,'hCAFEF00D,  1,0,           0,0,0,         0,0,           0,0,           1,0));
    vt.push_back(V(1,1,0,0, 0,0,          0,0,0,         0,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    // clr with mc_done on a load: abort wins, no pulse
    vt.push_back(V(1,1,0,0, 0,0,          1,0,'h2000,    2,0,           0,0,           1,0,'h2000,    2,0,           0,0,           0,0));
    vt.push_back(V(1,1,1,0, 0,0,          1,0,'h2000,    2,0,           1,'h99,        0,0,0,         0,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 0,0,          0,0,0,         0,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    // rdy stall with mc_done during the stall
    vt.push_back(V(1,1,0,0, 0,0,          1,1,'h3000,    1,'h12345678,  0,0,           1,1,'h3000,    1,'h12345678,  0,0,           0,0));
    for (int i = 0; i < 3; i++)
      vt.push_back(V(1,0,0,0, 0,0,        1,1,'h3000,    1,'h12345678,  1,0,           1,1,'h3000,    1,'h12345678,  0,0,           0,0));
    vt.push_back(V(1,1,0,0, 0,0,          1,1,'h3000,    1,'h12345678,  0,0,           1,1,'h3000,    1,'h12345678,  0,0,           0,0));
    vt.push_back(V(1,1,0,0, 0,0,          1,1,'h3000,    1,'h12345678,  1,0,           0,0,0,         0,0,           0,0,           1,0));
    vt.push_back(V(1,1,0,0, 0,0,          0,0,0,         0,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    // last grant becomes IF, then reset mid-fetch restores the IF-first tie-break
    vt.push_back(V(1,1,0,0, 1,'h400,      0,0,0,         0,0,           0,0,           1,0,'h400,     7,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 1,'h400,      0,0,0,         0,0,           1,'h55555555,  0,0,0,         0,0,           1,'h55555555,  0,0));
    vt.push_back(V(1,1,0,0, 0,0,          0,0,0,         0,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 1,'h404,      0,0,0,         0,0,           0,0,           1,0,'h404,     7,0,           0,0,           0,0));
    vt.push_back(V(0,1,0,0, 1,'h404,      1,0,'h500,     2,0,           0,0,           0,0,0,         0,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 1,'h404,      1,0,'h500,     2,0,           0,0,           1,0,'h404,     7,0,           0,0,           0,0));
    vt.push_back(V(1,1,0,0, 1,'h404,      1,0,'h500,     2,0,           1,'h77,        0,0,0,         0,0,           1,'h77,        0,0));

    foreach (vt[i]) begin
      rst_n = vt[i].rs; rdy = vt[i].rd; clr = vt[i].cl; io_full = vt[i].fu;
      if_req = vt[i].ir; if_addr = vt[i].ia; lsb_req = vt[i].lr; lsb_wr = vt[i].lw;
      lsb_addr = vt[i].la; lsb_ls_type = vt[i].lt; lsb_st_val = vt[i].lv;
      mc_done = vt[i].md; mc_result = vt[i].mr;
      step();
      chk($sformatf("vec%0d", i),
          pack(mc_enable, mc_wr, mc_addr, mc_ls_type, mc_st_val, if_done, if_data, lsb_done, lsb_ld_val,
               vt[i].een, vt[i].eid, vt[i].eld),
          pack(vt[i].een, vt[i].ewr, vt[i].ead, vt[i].ety, vt[i].esv, vt[i].eid, vt[i].eidt, vt[i].eld,
               vt[i].eldv, vt[i].een, vt[i].eid, vt[i].eld));
    end

    // done pulse frozen by rdy=0, released when rdy returns
    rst_n = 1; rdy = 1; clr = 0; mc_done = 0;
    if_req = 0; lsb_req = 1; lsb_wr = 0; lsb_addr = 32'h600; lsb_ls_type = 3'd4;
    begin
      int n;
      n = 0;
      do begin step(); n++; end while (!mc_enable && n < 4);
    end
    chk("hs_grant", {127'd0, mc_enable, mc_addr}, {127'd0, 1'b1, 32'h600});
    mc_done = 1; mc_result = 32'hFEEDFACE;
    step();
    mc_done = 0; lsb_req = 0;
    chk("hs_done", {127'd0, lsb_done, lsb_ld_val}, {127'd0, 1'b1, 32'hFEEDFACE});
    rdy = 0;
    step(); step();
    chk("hs_freeze", {158'd0, lsb_done, mc_enable}, {158'd0, 1'b1, 1'b0});
    rdy = 1;
    step();
    chk("hs_release", {158'd0, lsb_done, mc_enable}, {158'd0, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
